// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered read data, occupancy count and programmable
// almost-full/almost-empty flags. Define SYNC_FIFO_ERR_FLAGS_EN for sticky OVERFLOW/UNDERFLOW.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_EN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  R_EN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  R_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                  ERR_CLR,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
`endif
    output logic [ADDR_WIDTH:0]   COUNT
);

    localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rvalid;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;

    // Flags come straight from the registered count, so they lag the accepted operation by one cycle.
    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_wr_ok = W_EN && !w_full;
    assign w_rd_ok = R_EN && !w_empty;

    assign FULL         = w_full;
    assign EMPTY        = w_empty;
    assign ALMOST_FULL  = (r_count >= LP_AF);
    assign ALMOST_EMPTY = (r_count <= LP_AE);
    assign COUNT        = r_count;
    assign DATA_OUT     = r_dout;
    assign R_VALID      = r_rvalid;

    // Storage is never cleared; reset only invalidates it by rewinding the pointers.
    always_ff @(posedge CLK) begin
        if (w_wr_ok && !RST) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + LP_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + LP_ONE;
                r_dout <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + LP_ONE;
                2'b01:   r_count <= r_count - LP_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    // A set condition in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (W_EN && w_full) begin
                r_ovf <= 1'b1;
            end else if (ERR_CLR) begin
                r_ovf <= 1'b0;
            end
            if (R_EN && w_empty) begin
                r_udf <= 1'b1;
            end else if (ERR_CLR) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_udf;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a queue model predicts occupancy, flags
// and read data; a negedge monitor compares whatever the DUT presents.
module tb_sync_fifo_flags;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rv;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          ovf;
    logic          udf;
`endif

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .CLK(clk), .RST(rst), .W_EN(w_en), .DATA_IN(din), .R_EN(r_en),
        .DATA_OUT(dout), .R_VALID(rv), .FULL(full), .EMPTY(empty),
        .ALMOST_FULL(af), .ALMOST_EMPTY(ae),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .ERR_CLR(err_clr), .OVERFLOW(ovf), .UNDERFLOW(udf),
`endif
        .COUNT(count)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    logic          exp_rv = 1'b0;
    logic [DW-1:0] exp_dout = '0;
    bit            mon_en = 1'b0;
    bit            exp_ovf = 1'b0;
    bit            exp_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the FIFO is just a queue; acceptance is judged on the pre-edge occupancy.
    always @(posedge clk) begin : model
        bit f;
        bit e;
        bit wok;
        bit rok;
        if (rst) begin
            mq.delete();
            sb.delete();
            exp_rv   = 1'b0;
            exp_dout = '0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
            mon_en   = 1'b1;
        end else begin
            f   = (mq.size() == DEPTH);
            e   = (mq.size() == 0);
            wok = w_en && !f;
            rok = r_en && !e;
            exp_rv = rok;
            if (rok) begin
                exp_dout = mq.pop_front();
                sb.push_back(exp_dout);
            end
            if (wok) mq.push_back(din);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            exp_ovf = (w_en && f) ? 1'b1 : (err_clr ? 1'b0 : exp_ovf);
            exp_udf = (r_en && e) ? 1'b1 : (err_clr ? 1'b0 : exp_udf);
`endif
        end
    end

    always @(negedge clk) begin : monitor
        if (mon_en) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("almost_full", 32'(af), 32'(mq.size() >= AF));
            chk("almost_empty", 32'(ae), 32'(mq.size() <= AE));
            chk("r_valid", 32'(rv), 32'(exp_rv));
            chk("data_out_hold", 32'(dout), 32'(exp_dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            chk("overflow", 32'(ovf), 32'(exp_ovf));
            chk("underflow", 32'(udf), 32'(exp_udf));
`endif
            if (rv === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got %0h expected no read at %0t", dout, $time);
                end else begin
                    chk("rdata", 32'(dout), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit rs = 1'b0,
                         input bit clr = 1'b0);
        @(negedge clk);
        w_en = w;
        din  = d;
        r_en = r;
        rst  = rs;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = clr;
`endif
    endtask

    initial begin
        rst  = 1'b1;
        w_en = 1'b0;
        r_en = 1'b0;
        din  = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        // Fill with 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) drive(1, 8'(i), 0);
        // Writes while full are dropped, then clear the sticky flag
        drive(1, 8'hAA, 0);
        drive(1, 8'hAA, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0);
        // Drain completely, then one read against empty
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // Steady state at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) drive(1, 8'(8'h20 + i), 0);
        for (int i = 3; i < 43; i++) drive(1, 8'(8'h20 + i), 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1);
        drive(0, 0, 0);

        // Simultaneous write/read while empty: write only
        drive(1, 8'h5A, 1);
        drive(0, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);

        // Reset with 9 words queued, then new data only
        for (int i = 0; i < 9; i++) drive(1, 8'(8'hC0 + i), 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0);
        drive(1, 8'h77, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);

        // Randomized phases: write-biased, then read-biased, with rare resets
        for (int i = 0; i < 1200; i++) begin
            int wp;
            int rp;
            wp = (i < 600) ? 70 : 35;
            rp = (i < 600) ? 35 : 70;
            drive($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                  $urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0);
        end

        for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised next-generation synchronous FIFO with a registered read data path and an occupancy count. Adds programmable almost-full and almost-empty thresholds and a read-valid strobe. Used as the general buffering primitive between producer and consumer stages in the same clock domain, replacing fixed-size FIFOs that expose only FULL and EMPTY.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits (>=1)
FIFO_DEPTH, 16, number of entries; must be a power of two, >=4
ADDR_WIDTH, 4, log2(FIFO_DEPTH); pointers are ADDR_WIDTH+1 bits (extra wrap bit)
AF_THRESH, 12, ALMOST_FULL asserts when COUNT >= AF_THRESH (1..FIFO_DEPTH)
AE_THRESH, 4, ALMOST_EMPTY asserts when COUNT <= AE_THRESH (0..FIFO_DEPTH-1)

Ports:
CLK  input  1  clock; all logic on the rising edge
RST  input  1  reset, synchronous, active-high
W_EN  input  1  write request
DATA_IN  input  DATA_WIDTH  write data, sampled when the write is accepted
R_EN  input  1  read request
DATA_OUT  output  DATA_WIDTH  registered read data
R_VALID  output  1  1-cycle pulse: DATA_OUT was updated by an accepted read
FULL  output  1  COUNT == FIFO_DEPTH
EMPTY  output  1  COUNT == 0
ALMOST_FULL  output  1  COUNT >= AF_THRESH
ALMOST_EMPTY  output  1  COUNT <= AE_THRESH
COUNT  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (RST high at a rising edge): W_PTR=0, R_PTR=0, COUNT=0, DATA_OUT=0, R_VALID=0. After reset: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0. RST dominates W_EN and R_EN. Memory contents are not cleared.
- Reset mid-operation: all in-flight words are discarded. On the next cycle the FIFO is empty, regardless of earlier occupancy.
- Write accepted (wr_ok) = W_EN && !FULL. On wr_ok: MEM[W_PTR[ADDR_WIDTH-1:0]] <= DATA_IN and W_PTR increments.
- Read accepted (rd_ok) = R_EN && !EMPTY. On rd_ok: DATA_OUT <= MEM[R_PTR[ADDR_WIDTH-1:0]], R_PTR increments, and R_VALID=1 on the following cycle.
- Read latency: 1 clock from the R_EN edge to valid DATA_OUT. DATA_OUT holds its value when no read is accepted.
- FULL and EMPTY are evaluated on the current state, before the edge.
- Simultaneous W_EN and R_EN:
  - Not full and not empty: both are accepted and COUNT is unchanged.
  - FULL: only the read is accepted; the write is dropped; COUNT drops to FIFO_DEPTH-1.
  - EMPTY: only the write is accepted; no read, R_VALID=0; COUNT becomes 1. There is no write-to-read bypass.
- COUNT is a registered counter: +1 on wr_ok only, -1 on rd_ok only, otherwise unchanged. It must always equal W_PTR - R_PTR, modulo 2^(ADDR_WIDTH+1).
- Flags are decoded combinationally from the registered COUNT, so they update in the cycle after the accepted operation.
- Wrap-around: pointers roll from 2^(ADDR_WIDTH+1)-1 to 0. The address uses the low ADDR_WIDTH bits. Data order is preserved across any number of wraps.
- Rejected writes (write while FULL) and rejected reads (read while EMPTY) change no state.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds input ERR_CLR (1 bit) and outputs OVERFLOW and UNDERFLOW (1 bit each).
  - OVERFLOW sets on W_EN && FULL. UNDERFLOW sets on R_EN && EMPTY.
  - Both flags are sticky until ERR_CLR=1 or RST, and both reset to 0.
  - If a set condition and ERR_CLR occur in the same cycle, set wins.
- Not defined: these ports and registers do not exist; rejected operations are silently dropped. All other behaviour is identical.

Test Plan:
All scenarios use defaults (W=8, DEPTH=16, AF=12, AE=4).
1. Reset, then write 0x01..0x10 on consecutive cycles -> FULL=1 and COUNT=16 after the 16th write; ALMOST_FULL asserts the cycle after the 12th write; ALMOST_EMPTY deasserts after the 5th write.
2. From full, assert R_EN for 16 cycles -> DATA_OUT is 0x01..0x10 in order, 1 cycle after each R_EN, with an R_VALID pulse each time; EMPTY=1 and COUNT=0 at the end.
3. Write while FULL with DATA_IN=0xAA -> COUNT stays 16 and 0xAA is never read back. With SYNC_FIFO_ERR_FLAGS_EN: OVERFLOW=1 until ERR_CLR is pulsed.
4. Hold W_EN and R_EN high for 40 cycles starting at COUNT=3, writing an incrementing pattern -> COUNT stays 3, reads return the pattern in order across pointer wrap, and there is no data loss.
5. Simultaneous W_EN and R_EN while EMPTY with DATA_IN=0x5A -> COUNT=1, R_VALID=0, DATA_OUT unchanged. The next read returns 0x5A.
6. Assert RST mid-stream at COUNT=9 -> the next cycle shows EMPTY=1, COUNT=0, DATA_OUT=0, R_VALID=0, and a subsequent write/read returns the new data only.
